// File: rtl/smallcpu_pkg.sv
// Shared types and constants for the smallcpu serial path.
// Both the transmitter and the future receiver use this 8N1 frame format.
package smallcpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/smallcpu_sync_fifo.sv
// Small register-file FIFO with a combinational head read.
// Push is ignored when full and pop is ignored when empty.
module smallcpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  generate
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("smallcpu_sync_fifo: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + LW'(1);
    else if (do_pop && !do_push) count_d = count_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/smallcpu_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; ena low freezes the serialiser.
// tx is driven from a flop computed from the next state, so it never glitches.
module smallcpu_uart_tx
  import smallcpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [7:0]                   wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
      $error("smallcpu_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
  endgenerate

  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           pop;
  logic           bit_end;
  logic [7:0]     fifo_data;
  logic           fifo_full, fifo_empty;

  smallcpu_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign wr_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || (fifo_level != '0);
  assign tx       = tx_q;
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_data;
            baud_d    = '0;
            bit_idx_d = '0;
            state_d   = START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_d  = '0;
            state_d = DATA;
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_d = '0;
            if (bit_idx_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              shift_d   = shift_q >> 1;
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_d = '0;
            // Chain straight into the next frame when a byte is waiting.
            if (!fifo_empty) begin
              pop       = 1'b1;
              shift_d   = fifo_data;
              bit_idx_d = '0;
              state_d   = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_smallcpu_uart_tx.sv
// Directed bench for smallcpu_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Expected tx levels come from a small frame model driven by hand-picked bytes.
module tb_smallcpu_uart_tx;
  import smallcpu_pkg::*;

  localparam int CPB        = 4;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = UART_FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  smallcpu_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Frame position 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return b[i-1];
    else return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx actual=%b required=1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready actual=%b required=1", wr_ready); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level actual=%0d required=0", fifo_level); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_release_tx actual=%b required=1", tx); end
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    logic exp;
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_data  = 8'h3F;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level_push actual=%0d required=1", fifo_level); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_push actual=%b required=1", tx); end
    for (int k = 1; k <= FRAME_CLKS; k++) begin
      tick();
      exp = frame_bit(8'hA5, (k - 1) / CPB);
      n_checks++; if (tx !== exp) begin n_fail++; $display("FAIL single_tx k=%0d actual=%b required=%b", k, tx, exp); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy k=%0d actual=%b required=1", k, busy); end
      if (k == 1) begin
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level_pop actual=%0d required=0", fifo_level); end
      end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end actual=%b required=0", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_end actual=%b required=1", tx); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level_end actual=%0d required=0", fifo_level); end
    $display("test_single_byte done byte=a5");
  endtask

  task automatic test_back_to_back();
    logic       exp;
    logic [7:0] b;
    wr_data  = 8'h00;
    wr_valid = 1'b1;
    tick();
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL b2b_level_overlap actual=%0d required=1", fifo_level); end
    for (int k = 1; k <= 2 * FRAME_CLKS; k++) begin
      if (k > 1) tick();
      b   = ((k - 1) / FRAME_CLKS) != 0 ? 8'hFF : 8'h00;
      exp = frame_bit(b, ((k - 1) % FRAME_CLKS) / CPB);
      n_checks++; if (tx !== exp) begin n_fail++; $display("FAIL b2b_tx k=%0d actual=%b required=%b", k, tx, exp); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy k=%0d actual=%b required=1", k, busy); end
      if (k == FRAME_CLKS + 1) begin
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL b2b_level_second_pop actual=%0d required=0", fifo_level); end
      end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end actual=%b required=0", busy); end
    $display("test_back_to_back done bytes=00,ff");
  endtask

  task automatic test_backpressure();
    logic       exp;
    logic       acc;
    logic [7:0] b;
    int         sent;
    sent     = 0;
    wr_data  = 8'h01;
    wr_valid = 1'b1;
    for (int k = 0; k <= 6 * FRAME_CLKS; k++) begin
      acc = wr_valid && wr_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent < 6) wr_data = 8'(sent + 1);
        else wr_valid = 1'b0;
      end
      if (k == 4 || k == FRAME_CLKS) begin
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level_full k=%0d actual=%0d required=4", k, fifo_level); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full k=%0d actual=%b required=0", k, wr_ready); end
      end
      if (k == FRAME_CLKS + 1) begin
        n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL bp_level_pop actual=%0d required=3", fifo_level); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise actual=%b required=1", wr_ready); end
      end
      if (k == FRAME_CLKS + 2) begin
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level_sixth actual=%0d required=4", fifo_level); end
      end
      if (k >= 1) begin
        b   = 8'((k - 1) / FRAME_CLKS + 1);
        exp = frame_bit(b, ((k - 1) % FRAME_CLKS) / CPB);
        n_checks++; if (tx !== exp) begin n_fail++; $display("FAIL bp_tx k=%0d byte=%h actual=%b required=%b", k, b, tx, exp); end
      end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end actual=%b required=0", busy); end
    $display("test_backpressure done bytes=01..06");
  endtask

  task automatic test_enable_freeze();
    logic       exp;
    logic       en_edge;
    logic [7:0] b;
    int         c;
    int         k;
    wr_data  = 8'h3C;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    c = 0;
    k = 1;
    // c counts enabled edges since the pop, i.e. the frame position seen by the FSM.
    while (c < 2 * FRAME_CLKS && k < 300) begin
      b   = (c < FRAME_CLKS) ? 8'h3C : 8'h81;
      exp = frame_bit(b, (c % FRAME_CLKS) / CPB);
      n_checks++; if (tx !== exp) begin n_fail++; $display("FAIL freeze_tx k=%0d c=%0d actual=%b required=%b", k, c, tx, exp); end
      if (k == 18) ena = 1'b0;
      if (k == 25) ena = 1'b1;
      if (k == 20) begin
        wr_data  = 8'h81;
        wr_valid = 1'b1;
      end
      if (k == 21) begin
        wr_valid = 1'b0;
        n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL freeze_level_push actual=%0d required=1", fifo_level); end
      end
      en_edge = ena;
      tick();
      k++;
      if (en_edge) c++;
    end
    n_checks++; if (c != 2 * FRAME_CLKS) begin n_fail++; $display("FAIL freeze_timeout actual=%0d required=%0d", c, 2 * FRAME_CLKS); end
    n_checks++; if (k != 2 * FRAME_CLKS + 8) begin n_fail++; $display("FAIL freeze_duration actual=%0d required=%0d", k, 2 * FRAME_CLKS + 8); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL freeze_busy_end actual=%b required=0", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL freeze_tx_end actual=%b required=1", tx); end
    $display("test_enable_freeze done bytes=3c,81");
  endtask

  task automatic test_reset_mid_frame();
    wr_data  = 8'h55;
    wr_valid = 1'b1;
    tick();
    wr_data = 8'hAA;
    tick();
    wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL rstmid_level_queued actual=%0d required=1", fifo_level); end
    repeat (8) tick();
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_data actual=%b required=0", tx); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_async actual=%b required=1", tx); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level_async actual=%0d required=0", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_async actual=%b required=0", busy); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_async actual=%b required=1", wr_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_after k=%0d actual=%b required=1", k, tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after k=%0d actual=%b required=0", k, busy); end
    end
    $display("test_reset_mid_frame done bytes=55,aa");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_enable_freeze();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
